// File: rtl/axi_sram_pkg.sv
// Shared definitions for the AXI-to-SRAM bridges: burst/response codes,
// write FSM encoding and the legal transfer limits.
package axi_sram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_WORD   = 3'b010;
  localparam logic [7:0] MAX_LEN     = 8'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_BRESP = 2'd2
  } wr_state_e;

endpackage

// File: rtl/axi_wr_addr_gen.sv
// Burst word-address generator: loads the start word, steps it per beat for
// INCR bursts and flags a burst whose final word falls outside the SRAM.
module axi_wr_addr_gen #(
  parameter int ADDR_W = 32,
  parameter int RAM_AW = 14
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-3:0] start_word,
  input  logic [7:0]        len,
  input  logic              incr,
  input  logic              load,
  input  logic              step,
  output logic [RAM_AW-1:0] addr,
  output logic              range_err
);

  logic [ADDR_W-2:0] end_word;
  logic              incr_q;

  // One spare bit so start+len cannot wrap back into the legal range.
  assign end_word  = {1'b0, start_word} + (incr ? {{(ADDR_W-9){1'b0}}, len} : '0);
  assign range_err = |end_word[ADDR_W-2:RAM_AW];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr   <= '0;
      incr_q <= 1'b0;
    end else if (load) begin
      // A beat accepted alongside AW already consumed the start address.
      addr   <= start_word[RAM_AW-1:0] + {{(RAM_AW-1){1'b0}}, step & incr};
      incr_q <= incr;
    end else if (step && incr_q) begin
      addr   <= addr + 1'b1;
    end
  end

endmodule

// File: rtl/axi_sram_wr_bridge.sv
// AXI4 write responder (AW/W/B) driving single-cycle byte-masked SRAM writes.
// Optional macro AXI_WR_AW_W_SAME_CYCLE_EN lets beat 0 ride along with AW.
module axi_sram_wr_bridge
  import axi_sram_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int RAM_AW = 14
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  output logic                ram_en,
  output logic [DATA_W/8-1:0] ram_wen,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata
);

  wr_state_e         state, state_n;
  logic              rdy_q;
  logic [ID_W-1:0]   id_q;
  logic [7:0]        len_q, beat_cnt;
  logic              sup_q, err_q;
  logic              aw_hs, w_hs, aw_err, range_err, in_idle;
  logic              beat_last, beat_sup;
  logic [RAM_AW-1:0] gen_addr, beat_addr;

  axi_wr_addr_gen #(.ADDR_W(ADDR_W), .RAM_AW(RAM_AW)) u_addr_gen (
    .clk        (clk),
    .resetn     (resetn),
    .start_word (awaddr[ADDR_W-1:2]),
    .len        (awlen),
    .incr       (awburst == BURST_INCR),
    .load       (aw_hs),
    .step       (w_hs),
    .addr       (gen_addr),
    .range_err  (range_err)
  );

  assign aw_err = (awburst == BURST_WRAP) || (awburst == 2'b11) ||
                  (awsize != SIZE_WORD) || (awlen > MAX_LEN) ||
                  range_err || (awaddr[1:0] != 2'b00);

  // A beat seen in IDLE is beat 0 of the transaction being accepted right now.
  assign in_idle   = (state == ST_IDLE);
  assign beat_last = in_idle ? (awlen == 8'd0) : (beat_cnt == len_q);
  assign beat_sup  = in_idle ? aw_err : sup_q;
  assign beat_addr = in_idle ? awaddr[RAM_AW+1:2] : gen_addr;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_n = state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (state)
      ST_IDLE: begin
        awready = rdy_q;
`ifdef AXI_WR_AW_W_SAME_CYCLE_EN
        wready  = awvalid & rdy_q;
`endif
        if (awvalid && rdy_q)
          state_n = (wvalid && wready && awlen == 8'd0) ? ST_BRESP : ST_WDATA;
      end
      ST_WDATA: begin
        wready = 1'b1;
        if (wvalid && beat_last) state_n = ST_BRESP;
      end
      ST_BRESP: begin
        bvalid = 1'b1;
        if (bready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign bid   = id_q;
  assign bresp = (bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      rdy_q     <= 1'b0;
      id_q      <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      sup_q     <= 1'b0;
      err_q     <= 1'b0;
      ram_en    <= 1'b0;
      ram_wen   <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      state <= state_n;
      rdy_q <= 1'b1;
      if (aw_hs) begin
        id_q     <= awid;
        len_q    <= awlen;
        sup_q    <= aw_err;
        err_q    <= aw_err | (w_hs && (wlast != beat_last));
        beat_cnt <= w_hs ? 8'd1 : 8'd0;
      end else if (w_hs) begin
        beat_cnt <= beat_cnt + 8'd1;
        if (wlast != beat_last) err_q <= 1'b1;
      end
      // Zero-strobe beats still count but never touch the SRAM.
      ram_en <= w_hs && !beat_sup && (|wstrb);
      if (w_hs && !beat_sup && (|wstrb)) begin
        ram_wen   <= wstrb;
        ram_addr  <= beat_addr;
        ram_wdata <= wdata;
      end
    end
  end

endmodule

// File: doc/axi_sram_wr_bridge.md
Name: axi_sram_wr_bridge

Overview:
AXI4 write-channel responder (AW/W/B) that turns AXI write bursts into single-cycle SRAM byte-masked write strobes. It is the write-direction companion to the existing read bridge, and both share the same SRAM behind an arbiter outside this block. It handles one outstanding write transaction at a time and completes it with a single B response.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, AXI/SRAM data width (32 only; STRB_W = DATA_W/8)
ID_W, 4, AXI ID width
RAM_AW, 14, SRAM word-address width (capacity 2^RAM_AW words)

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
awid  in  ID_W  write address ID
awaddr  in  ADDR_W  byte start address
awlen  in  8  beats-1 (0..15 legal)
awsize  in  3  beat size
awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
awvalid  in  1  AW valid
awready  out  1  AW ready
wdata  in  DATA_W  write data
wstrb  in  STRB_W  byte strobes
wlast  in  1  last beat flag
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  ID_W  response ID (captured awid)
bresp  out  2  00 OKAY, 10 SLVERR
bvalid  out  1  B valid
bready  in  1  B ready
ram_en  out  1  SRAM write enable, one cycle per accepted beat
ram_wen  out  STRB_W  byte write mask
ram_addr  out  RAM_AW  SRAM word address
ram_wdata  out  DATA_W  SRAM write data

Behaviour:
- Reset (async, resetn=0): state IDLE; awready=0 during reset, 1 on the first cycle after release; wready=0, bvalid=0, bresp=00, bid=0, ram_en=0, ram_wen=0, ram_addr=0, ram_wdata=0; beat counter and error flag cleared. Reset mid-burst aborts it: no B response is sent, and no further SRAM writes occur.
- FSM states IDLE, WDATA, BRESP.
- IDLE: awready=1, wready=0. On awvalid&awready, capture awid, word address awaddr[RAM_AW+1:2], awlen, awburst; clear beat_cnt; go to WDATA.
- Error conditions are evaluated at AW acceptance and force suppressed writes plus bresp=SLVERR: awburst=WRAP or 11; awsize != 3'b010; awlen > 15; final word address (start+awlen for INCR) >= 2^RAM_AW; awaddr[1:0] != 0.
- WDATA: awready=0, wready=1. Each wvalid&wready is one beat:
  - Without error: registered ram_en=1, ram_wen=wstrb, ram_wdata=wdata, ram_addr=current word address, all visible the cycle after the handshake. ram_en=0 in every other cycle.
  - wstrb=0 still counts as a beat, but ram_en stays 0.
  - Address advances +1 per beat for INCR and stays fixed for FIXED.
  - When beat_cnt==len, go to BRESP.
  - If wlast differs from (beat_cnt==len), set the error flag, so bresp=SLVERR. Writes already issued are not undone. The burst length is always governed by awlen, never by wlast.
- BRESP: wready=0, awready=0, bvalid=1, bid=captured ID, bresp held stable until bready. On bvalid&bready go to IDLE, and awready=1 from the next cycle.
- Latency: AW handshake at cycle N; earliest W handshake at N+1; SRAM write at W handshake+1; bvalid at last W handshake+1. Back-to-back: next AW is accepted the cycle after the B handshake.
- No outstanding-transaction overlap. W beats presented in IDLE are not accepted (wready=0).

Optional Feature:
AXI_WR_AW_W_SAME_CYCLE_EN
- Defined: in IDLE, wready = awvalid, so the first beat may be accepted in the same cycle as AW, using awaddr directly as the beat-0 address. If awlen=0 in that case, the FSM goes straight from IDLE to BRESP.
- Undefined: wready=0 in IDLE; the first beat is accepted no earlier than the cycle after AW.

Decomposition:
- Shared package axi_sram_pkg:
  - BURST_FIXED/INCR/WRAP
  - RESP_OKAY/SLVERR
  - FSM state encoding
  - SIZE_WORD=3'b010
  - MAX_LEN=15
- One natural sub-module, axi_wr_addr_gen: captures the start address, increments or holds it per beat, and flags the out-of-range end address.
- The FSM and B channel stay in the top module.

Test Plan:
- Single write: awaddr=0x0, awlen=0, wdata=0x11223344, wstrb=F, wlast=1, bready=1 -> one ram_en pulse with ram_addr=0, ram_wen=F, ram_wdata=0x11223344; bvalid the next cycle with bresp=00, bid=awid.
- INCR burst: awaddr=0x100, awlen=3, data 1..4 with wvalid gaps -> ram_addr 0x40..0x43 in order, with exactly 4 ram_en pulses; one B with OKAY.
- Partial strobes plus FIXED burst: awburst=00, awlen=1, wstrb=3 then C -> both writes go to the same ram_addr with ram_wen 3 then C.
- Errors:
  - awburst=WRAP -> zero ram_en pulses, and bresp=10 after awlen+1 beats.
  - awaddr=0x10000 with RAM_AW=14 -> also SLVERR with writes suppressed.
- wlast mismatch plus B backpressure: awlen=1 with wlast=1 on beat 0 -> two writes issued and bresp=10; with bready=0 for 5 cycles, bvalid/bresp/bid are held and awready=0 throughout.
- Reset mid-burst: drop resetn after beat 1 of an awlen=3 burst -> all outputs 0 immediately with no B; after release, a fresh single write completes normally.
